mips_seq_alu: RTL

//  Datapath ALU consuming the 4-bit alu_control code produced by the ALU control unit.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mips_seq_mult.sv | 71 +++++++
 rtl/mips_seq_alu.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared ALU constants: control codes, default datapath width and the
// sequencing states used by the multi-cycle ALU.
package mips_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_FIX
    } alu_state_e;

endpackage

// File: rtl/mips_seq_mult.sv
// Unsigned magnitude shift-add multiplier. One partial product per cycle;
// 'last' is high during the cycle whose clock edge adds the final partial
// product, so acc is complete in the following cycle.
module mips_seq_mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 last,
    output logic [2*WIDTH-1:0]   acc
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic                 run_q, run_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    assign last = run_q && (cnt_q == CW'(WIDTH - 1));
    assign acc  = acc_q;

    // Next-state: load on start, otherwise one shift-add step per cycle while running
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mcand};
            mplier_d = mplier;
            acc_d    = '0;
        end else if (run_q) begin
            // mcand_q already holds |a| << count, so this adds the shifted multiplicand
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/mips_seq_alu.sv
// Sequential datapath ALU: single-cycle add/sub, iterative signed multiply
// into HI/LO, with a start/busy/done handshake for core stalling.
module mips_seq_alu
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = mips_pkg::ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegal
);

    alu_state_e         state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic               zero_q, zero_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               mult_start;
    logic               mult_last;
    logic [2*WIDTH-1:0] mult_acc;
    logic [WIDTH-1:0]   abs_a, abs_b, sum, diff;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) as unsigned
    always_comb begin
        abs_a = src_a[WIDTH-1] ? -src_a : src_a;
        abs_b = src_b[WIDTH-1] ? -src_b : src_b;
        sum   = src_a + src_b;
        diff  = src_a - src_b;
        prod  = sign_q ? -mult_acc : mult_acc;
    end

    mips_seq_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mult_start),
        .mcand  (abs_a),
        .mplier (abs_b),
        .last   (mult_last),
        .acc    (mult_acc)
    );

    // Decode, sequencing and output update
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        illegal_d  = illegal_q;
        zero_d     = zero_q;
        sign_d     = sign_q;
        result_d   = result_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mult_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    illegal_d = 1'b0;
                    case (alu_control)
                        ALU_ADD: begin
                            result_d = sum;
                            zero_d   = (sum == '0);
                            done_d   = 1'b1;
                        end
                        ALU_SUB: begin
                            result_d = diff;
                            zero_d   = (diff == '0);
                            done_d   = 1'b1;
                        end
                        ALU_MUL: begin
                            sign_d     = src_a[WIDTH-1] ^ src_b[WIDTH-1];
                            mult_start = 1'b1;
                            busy_d     = 1'b1;
                            state_d    = ST_MUL;
                        end
                        default: begin
                            illegal_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mult_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                {hi_d, lo_d} = prod;
                result_d     = prod[WIDTH-1:0];
                zero_d       = (prod == '0);
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Registered FSM state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b1;
            sign_q    <= 1'b0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            zero_q    <= zero_d;
            sign_q    <= sign_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign zero    = zero_q;
    assign result  = result_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
